// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath constants and ALU opcode encodings.
package riscv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CTRL_W = 4;
    localparam int unsigned REG_AW = 5;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1000;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode-side inputs, forwarding sources and ALU-side handshake.
interface id_ex_stage_if
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN   = riscv_pkg::XLEN,
    parameter int unsigned CTRL_W = riscv_pkg::CTRL_W
);

    logic                in_valid;
    logic                in_ready;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
    logic [XLEN-1:0]     imm;
    logic [REG_AW-1:0]   rs1_addr;
    logic [REG_AW-1:0]   rs2_addr;
    logic [REG_AW-1:0]   rd_addr;
    logic [CTRL_W-1:0]   alu_ctrl_in;
    logic                alu_src_imm;
    logic                reg_write_in;
    logic                flush;

    logic                exmem_we;
    logic [REG_AW-1:0]   exmem_rd;
    logic [XLEN-1:0]     exmem_result;
    logic                memwb_we;
    logic [REG_AW-1:0]   memwb_rd;
    logic [XLEN-1:0]     memwb_result;

    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     alu_a;
    logic [XLEN-1:0]     alu_b;
    logic [CTRL_W-1:0]   alu_ctrl;
    logic [REG_AW-1:0]   rd_out;
    logic                reg_write_out;

    // Environment side: decode, later pipeline stages and the ALU consumer.
    modport master (
        output in_valid, rs1_data, rs2_data, imm, rs1_addr, rs2_addr, rd_addr,
               alu_ctrl_in, alu_src_imm, reg_write_in, flush,
               exmem_we, exmem_rd, exmem_result, memwb_we, memwb_rd, memwb_result,
               out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_ctrl, rd_out, reg_write_out
    );

    // Pipeline register side.
    modport slave (
        input  in_valid, rs1_data, rs2_data, imm, rs1_addr, rs2_addr, rd_addr,
               alu_ctrl_in, alu_src_imm, reg_write_in, flush,
               exmem_we, exmem_rd, exmem_result, memwb_we, memwb_rd, memwb_result,
               out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_ctrl, rd_out, reg_write_out
    );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select: EX/MEM beats MEM/WB, x0 is never forwarded.
module fwd_mux
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [XLEN-1:0]   rs_data,
    input  logic              exmem_we,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic              memwb_we,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [XLEN-1:0]   memwb_result,
    output logic [XLEN-1:0]   fwd
);

    logic rs_nonzero;

    assign rs_nonzero = (rs_addr != REG_AW'(0));

    // Priority select of the youngest producer of this source register.
    always_comb begin
        fwd = rs_data;
        if (exmem_we && (exmem_rd == rs_addr) && rs_nonzero) begin
            fwd = exmem_result;
        end else if (memwb_we && (memwb_rd == rs_addr) && rs_nonzero) begin
            fwd = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake and operand forwarding.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN   = riscv_pkg::XLEN,
    parameter int unsigned CTRL_W = riscv_pkg::CTRL_W
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);

    logic                valid_q;
    logic [XLEN-1:0]     rs1_q;
    logic [XLEN-1:0]     rs2_q;
    logic [XLEN-1:0]     imm_q;
    logic [REG_AW-1:0]   rs1_addr_q;
    logic [REG_AW-1:0]   rs2_addr_q;
    logic [REG_AW-1:0]   rd_q;
    logic [CTRL_W-1:0]   ctrl_q;
    logic                src_imm_q;
    logic                reg_write_q;

    logic                in_ready_c;
    logic                capture;
    logic                stall;
    logic [XLEN-1:0]     fwd1;
    logic [XLEN-1:0]     fwd2;

    assign in_ready_c = !valid_q || bus.out_ready;
    assign capture    = bus.in_valid && in_ready_c;
    assign stall      = valid_q && !bus.out_ready;

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs_addr      (rs1_addr_q),
        .rs_data      (rs1_q),
        .exmem_we     (bus.exmem_we),
        .exmem_rd     (bus.exmem_rd),
        .exmem_result (bus.exmem_result),
        .memwb_we     (bus.memwb_we),
        .memwb_rd     (bus.memwb_rd),
        .memwb_result (bus.memwb_result),
        .fwd          (fwd1)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs_addr      (rs2_addr_q),
        .rs_data      (rs2_q),
        .exmem_we     (bus.exmem_we),
        .exmem_rd     (bus.exmem_rd),
        .exmem_result (bus.exmem_result),
        .memwb_we     (bus.memwb_we),
        .memwb_rd     (bus.memwb_rd),
        .memwb_result (bus.memwb_result),
        .fwd          (fwd2)
    );

    // Pipeline register: reset > flush > capture > drain/stall refresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            rs1_q       <= XLEN'(0);
            rs2_q       <= XLEN'(0);
            imm_q       <= XLEN'(0);
            rs1_addr_q  <= REG_AW'(0);
            rs2_addr_q  <= REG_AW'(0);
            rd_q        <= REG_AW'(0);
            ctrl_q      <= CTRL_W'(ALU_ADD);
            src_imm_q   <= 1'b0;
            reg_write_q <= 1'b0;
        end else if (bus.flush) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
        end else if (capture) begin
            valid_q     <= 1'b1;
            rs1_q       <= bus.rs1_data;
            rs2_q       <= bus.rs2_data;
            imm_q       <= bus.imm;
            rs1_addr_q  <= bus.rs1_addr;
            rs2_addr_q  <= bus.rs2_addr;
            rd_q        <= bus.rd_addr;
            ctrl_q      <= bus.alu_ctrl_in;
            src_imm_q   <= bus.alu_src_imm;
            reg_write_q <= bus.reg_write_in;
        end else if (stall) begin
            // Latch forwarded operands so they outlive their producer retiring.
            rs1_q <= fwd1;
            rs2_q <= fwd2;
        end else if (valid_q) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready      = in_ready_c;
    assign bus.out_valid     = valid_q;
    assign bus.alu_a         = fwd1;
    assign bus.alu_b         = src_imm_q ? imm_q : fwd2;
    assign bus.alu_ctrl      = ctrl_q;
    assign bus.rd_out        = rd_q;
    assign bus.reg_write_out = valid_q && reg_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus stall, flush, throughput and reset sequences.
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic clk;
    logic rst;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    typedef struct {
        logic [31:0] rs1_data;
        logic [4:0]  rs1_addr;
        logic [31:0] rs2_data;
        logic [4:0]  rs2_addr;
        logic [31:0] imm;
        logic        src_imm;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw;
        logic        ex_we;
        logic [4:0]  ex_rd;
        logic [31:0] ex_res;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_res;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid     = 1'b0;
        bus.rs1_data     = '0;
        bus.rs2_data     = '0;
        bus.imm          = '0;
        bus.rs1_addr     = '0;
        bus.rs2_addr     = '0;
        bus.rd_addr      = '0;
        bus.alu_ctrl_in  = '0;
        bus.alu_src_imm  = 1'b0;
        bus.reg_write_in = 1'b0;
        bus.flush        = 1'b0;
        bus.exmem_we     = 1'b0;
        bus.exmem_rd     = '0;
        bus.exmem_result = '0;
        bus.memwb_we     = 1'b0;
        bus.memwb_rd     = '0;
        bus.memwb_result = '0;
        bus.out_ready    = 1'b1;
    endtask

    task automatic drive_vec(input vec_t v);
        bus.rs1_data     = v.rs1_data;
        bus.rs1_addr     = v.rs1_addr;
        bus.rs2_data     = v.rs2_data;
        bus.rs2_addr     = v.rs2_addr;
        bus.imm          = v.imm;
        bus.alu_src_imm  = v.src_imm;
        bus.alu_ctrl_in  = v.ctrl;
        bus.rd_addr      = v.rd;
        bus.reg_write_in = v.rw;
        bus.exmem_we     = v.ex_we;
        bus.exmem_rd     = v.ex_rd;
        bus.exmem_result = v.ex_res;
        bus.memwb_we     = v.wb_we;
        bus.memwb_rd     = v.wb_rd;
        bus.memwb_result = v.wb_res;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        //        rs1_d  a  rs2_d  a  imm          si ctrl     rd rw  exwe rd exres   wbwe rd wbres   exp_a  exp_b
        vecs[0] = '{32'd5,  1, 32'd7,  2, 32'd0,        0, ALU_ADD, 4, 1, 0, 0, 32'd0,  0, 0, 32'd0,  32'd5,  32'd7};
        vecs[1] = '{32'h11, 3, 32'h22, 4, 32'd0,        0, ALU_SUB, 5, 1, 1, 3, 32'hAA, 1, 3, 32'hBB, 32'hAA, 32'h22};
        vecs[2] = '{32'd0,  0, 32'd8,  6, 32'd0,        0, ALU_AND, 6, 0, 1, 0, 32'hFF, 0, 0, 32'd0,  32'd0,  32'd8};
        vecs[3] = '{32'd9,  6, 32'h1,  5, 32'd0,        0, ALU_OR,  7, 1, 0, 0, 32'd0,  1, 5, 32'h55, 32'd9,  32'h55};
        vecs[4] = '{32'd3,  2, 32'h1,  3, 32'hFFFFFFFC, 1, ALU_SLT, 8, 1, 1, 3, 32'h99, 0, 0, 32'd0,  32'd3,  32'hFFFFFFFC};
        vecs[5] = '{32'h40, 9, 32'h50, 9, 32'd0,        0, ALU_SRA, 9, 1, 0, 9, 32'h66, 1, 9, 32'h77, 32'h77, 32'h77};

        // Reset state
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_reg_write", 32'(bus.reg_write_out), 32'd0);
        chk("rst_rd_out",    32'(bus.rd_out), 32'd0);
        chk("rst_alu_ctrl",  32'(bus.alu_ctrl), 32'(ALU_ADD));
        chk("rst_alu_a",     bus.alu_a, 32'd0);
        chk("rst_alu_b",     bus.alu_b, 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready), 32'd1);

        // Table of single-instruction transactions
        for (int i = 0; i < 6; i++) begin
            drive_vec(vecs[i]);
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("v%0d_alu_a", i), bus.alu_a, vecs[i].exp_a);
            chk($sformatf("v%0d_alu_b", i), bus.alu_b, vecs[i].exp_b);
            chk($sformatf("v%0d_rd_out", i), 32'(bus.rd_out), 32'(vecs[i].rd));
            chk($sformatf("v%0d_alu_ctrl", i), 32'(bus.alu_ctrl), 32'(vecs[i].ctrl));
            chk($sformatf("v%0d_reg_write", i), 32'(bus.reg_write_out), 32'(vecs[i].rw));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_drained", i), 32'(bus.out_valid), 32'd0);
            chk($sformatf("v%0d_rw_gated", i), 32'(bus.reg_write_out), 32'd0);
        end

        // Stall: forwarded value captured during stall must survive producer retiring
        idle_inputs();
        bus.rs1_addr = 5'd3; bus.rs1_data = 32'd1;
        bus.rs2_addr = 5'd4; bus.rs2_data = 32'd2;
        bus.rd_addr = 5'd9; bus.reg_write_in = 1'b1; bus.alu_ctrl_in = ALU_XOR;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rs1_data = 32'h77; bus.rd_addr = 5'd12; bus.alu_ctrl_in = ALU_SLL;
        bus.out_ready = 1'b0;
        bus.exmem_we = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'h10;
        #1;
        chk("stall0_alu_a", bus.alu_a, 32'h10);
        chk("stall0_in_ready", 32'(bus.in_ready), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1 bus.exmem_we = 1'b0;
            #1;
            chk($sformatf("stall%0d_alu_a", c), bus.alu_a, 32'h10);
            chk($sformatf("stall%0d_alu_b", c), bus.alu_b, 32'd2);
            chk($sformatf("stall%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
            chk($sformatf("stall%0d_out_valid", c), 32'(bus.out_valid), 32'd1);
            chk($sformatf("stall%0d_rd_out", c), 32'(bus.rd_out), 32'd9);
            chk($sformatf("stall%0d_alu_ctrl", c), 32'(bus.alu_ctrl), 32'(ALU_XOR));
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_drained", 32'(bus.out_valid), 32'd0);

        // Flush overrides a simultaneous capture; in_ready unaffected
        idle_inputs();
        bus.rd_addr = 5'd2; bus.reg_write_in = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_addr = 5'd3; bus.flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        #1;
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_reg_write", 32'(bus.reg_write_out), 32'd0);

        // Back-to-back throughput with immediate operand
        idle_inputs();
        bus.alu_src_imm = 1'b1; bus.imm = 32'hFFFFFFFC; bus.reg_write_in = 1'b1;
        bus.rd_addr = 5'd1; bus.in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b2b%0d_out_valid", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("b2b%0d_rd_out", k), 32'(bus.rd_out), 32'(k));
            chk($sformatf("b2b%0d_alu_b", k), bus.alu_b, 32'hFFFFFFFC);
            chk($sformatf("b2b%0d_in_ready", k), 32'(bus.in_ready), 32'd1);
            bus.rd_addr = 5'(k + 1);
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_drained", 32'(bus.out_valid), 32'd0);

        // Reset wins over capture and flush
        idle_inputs();
        bus.rd_addr = 5'd17; bus.reg_write_in = 1'b1; bus.in_valid = 1'b1; bus.flush = 1'b1;
        bus.alu_ctrl_in = ALU_SUB; bus.rs1_data = 32'h5A;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; bus.in_valid = 1'b0; bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("rstpri_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rstpri_rd_out", 32'(bus.rd_out), 32'd0);
        chk("rstpri_alu_ctrl", 32'(bus.alu_ctrl), 32'(ALU_ADD));
        chk("rstpri_alu_a", bus.alu_a, 32'd0);
        chk("rstpri_in_ready", 32'(bus.in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
